// File: rtl/reg_file_mp_if.sv
// Decoder/ALU-facing bundle of the multi-port register file.
// The master side drives addresses, write requests and flag updates.
interface reg_file_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic                     wr_sel;
  logic [DATA_W-1:0]        wr_data_alu;
  logic [DATA_W-1:0]        wr_data_id;
  logic [1:0]               wr_mode;
  logic                     cpsr_wr_en;
  logic [3:0]               cpsr_wr_mask;
  logic [3:0]               cpsr_wr_data;
  logic [3:0]               cpsr;
  logic                     clr_all;
  logic                     busy;
  logic                     wr_drop;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_sel, wr_data_alu, wr_data_id, wr_mode,
    output cpsr_wr_en, cpsr_wr_mask, cpsr_wr_data, clr_all,
    input  rd_data, cpsr, busy, wr_drop
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_sel, wr_data_alu, wr_data_id, wr_mode,
    input  cpsr_wr_en, cpsr_wr_mask, cpsr_wr_data, clr_all,
    output rd_data, cpsr, busy, wr_drop
  );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with half-word write modes,
// write-to-read bypass, masked NZCV flags and a multi-cycle clear-all sweep.
module reg_file_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NUM_RD = 2,
  parameter bit          BYPASS = 1'b1
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int H        = DATA_W / 2;

  typedef enum logic {StIdle, StSweep} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              wr_drop_q;
  logic [3:0]        cpsr_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [DATA_W-1:0]        src;
  logic [H-1:0]             old_lo;
  logic [DATA_W-1:0]        merged;
  logic                     wr_fire;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;

  assign src     = bus.wr_sel ? bus.wr_data_id : bus.wr_data_alu;
  assign old_lo  = regs_q[bus.wr_addr][H-1:0];
  assign wr_fire = bus.wr_en && !busy_q;

  always_comb begin
    merged = '0;
    unique case (bus.wr_mode)
      2'b00: merged = src;
      2'b01: merged = {{(DATA_W-H){1'b0}}, src[H-1:0]};
      2'b10: merged = {src[H-1:0], old_lo};
      2'b11: merged = '0;
      default: merged = '0;
    endcase
  end

  // Forwarding is suppressed while sweeping because wr_fire is gated by busy.
  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (BYPASS && wr_fire && (bus.rd_addr[k*ADDR_W +: ADDR_W] == bus.wr_addr)) begin
        rd_data_c[k*DATA_W +: DATA_W] = merged;
      end else begin
        rd_data_c[k*DATA_W +: DATA_W] = regs_q[bus.rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      cpsr_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (bus.cpsr_wr_en) begin
        cpsr_q <= (cpsr_q & ~bus.cpsr_wr_mask) | (bus.cpsr_wr_data & bus.cpsr_wr_mask);
      end
      wr_drop_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.wr_en) begin
            regs_q[bus.wr_addr] <= merged;
          end
          if (bus.clr_all) begin
            state_q <= StSweep;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StSweep: begin
          regs_q[cnt_q] <= '0;
          cnt_q         <= cnt_q + 1'b1;
          wr_drop_q     <= bus.wr_en;
          if (cnt_q == '1) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.cpsr    = cpsr_q;
  assign bus.busy    = busy_q;
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one bypassing and one non-bypassing instance
// driven identically, expectations queued as stimulus is applied.
module tb_reg_file_mp;
  logic clk;
  logic rst;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(2)) bus_a ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(2)) bus_b ();

  reg_file_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(2), .BYPASS(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(2), .BYPASS(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  assign bus_b.rd_addr      = bus_a.rd_addr;
  assign bus_b.wr_en        = bus_a.wr_en;
  assign bus_b.wr_addr      = bus_a.wr_addr;
  assign bus_b.wr_sel       = bus_a.wr_sel;
  assign bus_b.wr_data_alu  = bus_a.wr_data_alu;
  assign bus_b.wr_data_id   = bus_a.wr_data_id;
  assign bus_b.wr_mode      = bus_a.wr_mode;
  assign bus_b.cpsr_wr_en   = bus_a.cpsr_wr_en;
  assign bus_b.cpsr_wr_mask = bus_a.cpsr_wr_mask;
  assign bus_b.cpsr_wr_data = bus_a.cpsr_wr_data;
  assign bus_b.clr_all      = bus_a.clr_all;

  logic [31:0] rd0_a, rd1_a, rd0_b;
  assign rd0_a = bus_a.rd_data[31:0];
  assign rd1_a = bus_a.rd_data[63:32];
  assign rd0_b = bus_b.rd_data[31:0];

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
    bus_a.rd_addr = {a1, a0};
    #1;
  endtask

  task automatic drive_wr(input logic [2:0] addr, input logic sel, input logic [1:0] mode,
                          input logic [31:0] data);
    bus_a.wr_en       = 1'b1;
    bus_a.wr_addr     = addr;
    bus_a.wr_sel      = sel;
    bus_a.wr_mode     = mode;
    bus_a.wr_data_alu = sel ? 32'h0 : data;
    bus_a.wr_data_id  = sel ? data : 32'h0;
  endtask

  task automatic check_all(input string tag, input int skip, input logic [31:0] skip_val);
    for (int i = 0; i < 8; i++) begin
      set_rd(3'(i), 3'(i));
      push_exp(tag, (i == skip) ? skip_val : 32'h0);
      check(rd0_a);
      push_exp(tag, (i == skip) ? skip_val : 32'h0);
      check(rd1_a);
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus_a.rd_addr      = '0;
    bus_a.wr_en        = 1'b0;
    bus_a.wr_addr      = '0;
    bus_a.wr_sel       = 1'b0;
    bus_a.wr_data_alu  = '0;
    bus_a.wr_data_id   = '0;
    bus_a.wr_mode      = 2'b00;
    bus_a.cpsr_wr_en   = 1'b0;
    bus_a.cpsr_wr_mask = '0;
    bus_a.cpsr_wr_data = '0;
    bus_a.clr_all      = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check_all("reset_regs", -1, 32'h0);
    push_exp("reset_cpsr", 32'h0);    check({28'h0, bus_a.cpsr});
    push_exp("reset_busy", 32'h0);    check({31'h0, bus_a.busy});
    push_exp("reset_wr_drop", 32'h0); check({31'h0, bus_a.wr_drop});

    // FULL write from ALU to R3
    set_rd(3'd2, 3'd2);
    drive_wr(3'd3, 1'b0, 2'b00, 32'hDEADBEEF);
    step();
    bus_a.wr_en = 1'b0;
    check_all("full_r3", 3, 32'hDEADBEEF);
    set_rd(3'd3, 3'd3);
    push_exp("full_r3_nobyp", 32'hDEADBEEF); check(rd0_b);

    // LOW then HIGH from ID to R0
    drive_wr(3'd0, 1'b1, 2'b01, 32'hABCD1234);
    step();
    bus_a.wr_en = 1'b0;
    set_rd(3'd0, 3'd0);
    push_exp("low_r0", 32'h00001234); check(rd0_a);
    drive_wr(3'd0, 1'b1, 2'b10, 32'h0000FFFF);
    #1;
    push_exp("high_byp", 32'hFFFF1234);   check(rd0_a);
    push_exp("high_nobyp", 32'h00001234); check(rd0_b);
    step();
    bus_a.wr_en = 1'b0;
    #1;
    push_exp("high_r0", 32'hFFFF1234); check(rd1_a);

    // Bypass vs no bypass on R5
    set_rd(3'd5, 3'd5);
    drive_wr(3'd5, 1'b0, 2'b00, 32'h55);
    #1;
    push_exp("byp_r5", 32'h55);   check(rd0_a);
    push_exp("nobyp_r5", 32'h0);  check(rd0_b);
    step();
    bus_a.wr_en = 1'b0;
    #1;
    push_exp("nobyp_r5_after", 32'h55); check(rd0_b);

    // Masked CPSR
    bus_a.cpsr_wr_en = 1'b1; bus_a.cpsr_wr_mask = 4'b1010; bus_a.cpsr_wr_data = 4'b1111;
    step();
    push_exp("cpsr_1010", 32'hA); check({28'h0, bus_a.cpsr});
    bus_a.cpsr_wr_mask = 4'b0101; bus_a.cpsr_wr_data = 4'b0000;
    step();
    push_exp("cpsr_hold", 32'hA); check({28'h0, bus_a.cpsr});
    bus_a.cpsr_wr_mask = 4'b0001; bus_a.cpsr_wr_data = 4'b0001;
    step();
    bus_a.cpsr_wr_en = 1'b0;
    push_exp("cpsr_v", 32'hB); check({28'h0, bus_a.cpsr});

    // Fill all registers, then sweep with a dropped write in the third busy cycle
    for (int i = 0; i < 8; i++) begin
      drive_wr(3'(i), 1'b0, 2'b00, 32'h1000_0001 + 32'(i));
      step();
    end
    bus_a.wr_en   = 1'b0;
    bus_a.clr_all = 1'b1;
    step();
    bus_a.clr_all = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      push_exp("sweep_busy", 32'h1);                check({31'h0, bus_a.busy});
      push_exp("sweep_drop", (c == 4) ? 32'h1 : 32'h0); check({31'h0, bus_a.wr_drop});
      if (c == 3) begin
        set_rd(3'd2, 3'd2);
        drive_wr(3'd2, 1'b0, 2'b00, 32'h77);
        #1;
        push_exp("sweep_no_byp", 32'h1000_0003); check(rd0_a);
      end
      step();
      bus_a.wr_en = 1'b0;
    end
    push_exp("sweep_done_busy", 32'h0); check({31'h0, bus_a.busy});
    push_exp("sweep_done_drop", 32'h0); check({31'h0, bus_a.wr_drop});
    check_all("sweep_cleared", -1, 32'h0);

    // Reset in the fourth sweep cycle
    drive_wr(3'd6, 1'b0, 2'b00, 32'h66);
    bus_a.cpsr_wr_en = 1'b1; bus_a.cpsr_wr_mask = 4'hF; bus_a.cpsr_wr_data = 4'hF;
    step();
    bus_a.wr_en = 1'b0; bus_a.cpsr_wr_en = 1'b0;
    bus_a.clr_all = 1'b1;
    step();
    bus_a.clr_all = 1'b0;
    step();
    step();
    step();
    push_exp("pre_rst_busy", 32'h1); check({31'h0, bus_a.busy});
    rst = 1'b1;
    step();
    rst = 1'b0;
    push_exp("rst_busy", 32'h0); check({31'h0, bus_a.busy});
    push_exp("rst_cpsr", 32'h0); check({28'h0, bus_a.cpsr});
    check_all("rst_regs", -1, 32'h0);
    step();
    push_exp("rst_busy_stays", 32'h0); check({31'h0, bus_a.busy});

    drive_wr(3'd4, 1'b0, 2'b00, 32'hCAFEF00D);
    step();
    bus_a.wr_en = 1'b0;
    set_rd(3'd4, 3'd1);
    push_exp("post_rst_wr", 32'hCAFEF00D); check(rd0_a);
    push_exp("post_rst_r1", 32'h0);        check(rd1_a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the single-register-file datapath block (2 read ports, 8×32 registers, ALU/ID write select, separate CPSR file).
- Adds:
  - N read ports
  - Configurable width and depth
  - MOV/MOVT half-word write modes
  - Same-cycle write→read bypass
  - Masked NZCV CPSR update
  - Multi-cycle clear-all sweep with busy/drop signalling
- Sits between the instruction decoder (addresses, modes, immediates) and the ALU (operands, result, flags).

Parameters:
- DATA_W, 32: register width; must be even and ≥ 4.
- ADDR_W, 3: address width; NUM_REGS = 2**ADDR_W.
- NUM_RD, 2: number of read ports.
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return array contents only.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]. Combinational.
- wr_en  in  1  register write request.
- wr_addr  in  ADDR_W  write address.
- wr_sel  in  1  write source: 0 = wr_data_alu, 1 = wr_data_id.
- wr_data_alu  in  DATA_W  ALU result.
- wr_data_id  in  DATA_W  decoder immediate.
- wr_mode  in  2  write mode:
  - 00 FULL
  - 01 LOW (zero-extend low half)
  - 10 HIGH (replace upper half, keep lower)
  - 11 CLR (write 0)
- cpsr_wr_en  in  1  CPSR update request.
- cpsr_wr_mask  in  4  per-flag enable, bit order {N,Z,C,V}.
- cpsr_wr_data  in  4  new flag values, bit order {N,Z,C,V}.
- cpsr  out  4  current flags. Registered.
- clr_all  in  1  start clear-all sweep (level sampled).
- busy  out  1  sweep in progress. Registered.
- wr_drop  out  1  one-cycle pulse when a write was discarded. Registered.

Behaviour:
- Reset (rst=1 at a rising edge):
  - all registers = 0
  - cpsr = 0
  - busy = 0, wr_drop = 0
  - sweep counter = 0
  - Reset overrides any sweep in progress and any write in the same cycle.
- Source value: src = wr_sel ? wr_data_id : wr_data_alu.
- Merged value by wr_mode (H = DATA_W/2):
  - FULL: src
  - LOW: {H zeros, src[H-1:0]}
  - HIGH: {src[H-1:0], old[H-1:0]}, where old is the current contents of wr_addr
  - CLR: 0
- Write timing: when wr_en=1 and busy=0, the merged value is stored at the next rising edge. Write latency is 1 cycle.
- Read port k:
  - If BYPASS=1, wr_en=1, busy=0 and rd_addr_k == wr_addr, return the merged value (combinational forward).
  - Otherwise return the array contents.
  - Multiple ports may read the same address.
- CPSR: on an edge with cpsr_wr_en=1, each flag i takes cpsr_wr_data[i] when cpsr_wr_mask[i]=1 and holds otherwise. CPSR updates are independent of busy and of the sweep.
- State machine:
  - IDLE: if clr_all=1, go to SWEEP with cnt=0 and busy=1 on the next edge. A register write requested in the same cycle is still performed (clr_all is sampled alongside it); the sweep later zeroes that register.
  - SWEEP:
    - Each cycle writes 0 to reg[cnt], then cnt increments.
    - After writing reg[NUM_REGS-1]: busy=0, return to IDLE. busy is high for exactly NUM_REGS cycles.
    - clr_all while in SWEEP is ignored; there is no restart.
    - wr_en=1 while in SWEEP: the write is discarded and wr_drop=1 on the following cycle.
    - Reads during SWEEP return array contents with no bypass.
- wr_drop is 0 in every cycle not covered by the discard rule above.
- cnt wraps naturally at ADDR_W bits. No out-of-range address exists.

Test Plan:
- Reset, then FULL write of 0xDEADBEEF from ALU to R3 → R3 reads 0xDEADBEEF the next cycle on both ports. All other registers read 0 and cpsr=0.
- LOW write of src 0xABCD1234 from ID to R0 → R0 reads 0x00001234. Then HIGH write of 0x0000FFFF → R0 reads 0xFFFF1234.
- With BYPASS=1: write 0x55 to R5 while rd_addr port0=5 in the same cycle → rd_data0=0x55 combinationally. With BYPASS=0 the same stimulus gives the old value (0) until the next edge.
- CPSR write with mask=1010, data=1111 from cpsr=0000 → cpsr=1010. Then mask=0101, data=0000 → cpsr stays 1010.
- Fill R0..R7 with nonzero values, pulse clr_all → busy high for exactly 8 cycles and all registers read 0 afterwards. A wr_en to R2 in the third busy cycle gives wr_drop=1 for one cycle and R2 stays 0.
- Assert rst in the fourth cycle of a sweep → the next cycle has busy=0, all registers 0 and cpsr 0. A following normal write succeeds.
